// File: rtl/mem_arbiter_if.sv
// Purpose: groups the VGA fetch, CPU load/store and BRAM signals of the data-memory arbiter.
// Latency: none, this file only declares wires and modports.
// Backpressure: each requester holds its req until it sees ack; there is no BRAM stall.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: takes requests and BRAM read data, drives acks, read returns and the BRAM port.
  modport slave (
    input  vga_req, vga_addr,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vga_ack, vga_rvalid, vga_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Environment side: the requesters and the BRAM.
  modport master (
    output vga_req, vga_addr,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vga_ack, vga_rvalid, vga_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-port BRAM between VGA (default priority) and the CPU, with a starvation guard.
// Latency: ack is combinational in the request cycle; read data and rvalid follow one cycle after the grant.
// Backpressure: the loser simply sees no ack and holds its req; the CPU is forced through after MAX_DEFER losses.
module mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int MAX_DEFER = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] DEFER_MAX = 4'(MAX_DEFER);

  // Which requester, if any, owns the read data coming back from the BRAM next cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_CPU  = 2'd2
  } tag_e;

  tag_e              rd_tag, rd_tag_nxt;
  logic [3:0]        defer_cnt, defer_cnt_nxt;
  logic              grant_vga, grant_cpu;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] rdata;

  // Register the read-return tag and the count of consecutive CPU losses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag    <= TAG_NONE;
      defer_cnt <= 4'd0;
    end else begin
      rd_tag    <= rd_tag_nxt;
      defer_cnt <= defer_cnt_nxt;
    end
  end

  // Pick at most one winner per cycle, drive the BRAM port and work out the next tag and defer count.
  always_comb begin
    grant_vga     = 1'b0;
    grant_cpu     = 1'b0;
    grant_addr    = bus.vga_addr;
    rd_tag_nxt    = TAG_NONE;
    defer_cnt_nxt = defer_cnt;

    // VGA wins any contest unless the CPU has already lost DEFER_MAX times in a row.
    grant_vga = bus.vga_req && !(bus.cpu_req && (defer_cnt == DEFER_MAX));
    grant_cpu = bus.cpu_req && !grant_vga;

    if (grant_cpu) begin
      grant_addr = bus.cpu_addr;
    end

    if (grant_vga) begin
      rd_tag_nxt = TAG_VGA;
    end else if (grant_cpu && !bus.cpu_we) begin
      rd_tag_nxt = TAG_CPU;
    end

    // Only a CPU that is actually waiting accumulates losses; a grant or a dropped req starts over.
    if (!bus.cpu_req || grant_cpu) begin
      defer_cnt_nxt = 4'd0;
    end else if (defer_cnt < DEFER_MAX) begin
      defer_cnt_nxt = defer_cnt + 4'd1;
    end
  end

  assign rdata = bus.mem_rdata;

  assign bus.vga_ack   = grant_vga;
  assign bus.cpu_ack   = grant_cpu;
  assign bus.mem_en    = grant_vga || grant_cpu;
  assign bus.mem_we    = (grant_cpu && bus.cpu_we) ? bus.cpu_be : 4'b0000;
  assign bus.mem_addr  = grant_addr;
  assign bus.mem_wdata = bus.cpu_wdata;

  // Both requesters see the raw BRAM output; only the tagged owner gets a strobe.
  assign bus.vga_rvalid = (rd_tag == TAG_VGA);
  assign bus.cpu_rvalid = (rd_tag == TAG_CPU);
  assign bus.vga_rdata  = rdata;
  assign bus.cpu_rdata  = rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port synchronous data BRAM between the CPU load/store port and the VGA pixel fetch unit inside top. VGA has default priority because its timing is hard real-time. A starvation counter guarantees the CPU a slot after MAX_DEFER consecutive losses. Read data is returned with fixed 1-cycle latency and a tagged valid strobe per requester.

Parameters:
ADDR_W, 14, word address width of the shared BRAM
DATA_W, 32, data width (must be 32; byte enables are 4 bits)
MAX_DEFER, 4, consecutive cycles the CPU may lose before a forced CPU grant (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
vga_req  in  1  VGA read request, held until vga_ack
vga_addr  in  ADDR_W  VGA read word address
vga_ack  out  1  VGA request accepted this cycle (combinational)
vga_rvalid  out  1  vga_rdata valid (registered strobe)
vga_rdata  out  DATA_W  VGA read data
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_be  in  4  byte enables for writes
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid (registered strobe, reads only)
cpu_rdata  out  DATA_W  CPU read data
mem_en  out  1  BRAM enable
mem_we  out  4  BRAM byte write enables
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, valid 1 cycle after mem_en

Behaviour:
- Reset (rst=0, async): defer_cnt=0, rd_tag=NONE, vga_rvalid=0, cpu_rvalid=0. Combinational outputs follow from reset state: with no requests, all acks/mem_en/mem_we=0.
- Grant (combinational, per cycle, at most one winner):
  - only vga_req -> VGA; only cpu_req -> CPU; neither -> idle (mem_en=0, mem_we=0, mem_addr/mem_wdata don't-care).
  - both, defer_cnt < MAX_DEFER -> VGA wins; both, defer_cnt == MAX_DEFER -> CPU wins.
- Winner gets ack=1 in the same cycle; mem_en=1, mem_addr=winner address. VGA: mem_we=0. CPU: mem_we = cpu_we ? cpu_be : 4'b0000, mem_wdata=cpu_wdata. A CPU write with cpu_be=0 is still acked and consumes the slot.
- defer_cnt (registered, saturates at MAX_DEFER): increments when cpu_req=1 and VGA wins. Clears when CPU is granted or cpu_req=0.
- Read return: rd_tag registers {VGA, CPU-read, NONE} at the grant edge; CPU writes tag NONE.
  - Next cycle: vga_rvalid=1 if tag=VGA; cpu_rvalid=1 if tag=CPU-read; never both.
  - vga_rdata and cpu_rdata are both driven from mem_rdata (consumers qualify with rvalid).
- Throughput: one access per cycle, back-to-back, with no bubbles between grants, including grants that switch requester.
- Requesters drop or change req/addr only after the edge where ack=1. The arbiter does not check this.
- Reset mid-operation: a pending rvalid is cancelled, defer_cnt clears, and no strobe appears after rst rises. Any in-flight BRAM read is discarded.

Test Plan:
- CPU-only read of addr 0x0010, BRAM holds 0xDEADBEEF -> cpu_ack in cycle N, mem_en=1, mem_we=0; cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1 only.
- CPU write addr 0x0020, wdata 0x12345678, be=4'b0011 -> mem_we=4'b0011 in grant cycle; cpu_rvalid stays 0; later read returns lower 16 bits 0x5678 merged with old upper bytes.
- vga_req and cpu_req held high continuously, MAX_DEFER=4 -> grant pattern VGA,VGA,VGA,VGA,CPU repeating; defer_cnt peaks at 4; vga_rvalid/cpu_rvalid follow the grants one cycle later.
- Alternating VGA read 0x0100 then CPU read 0x0200 back-to-back -> consecutive mem_en cycles; vga_rvalid then cpu_rvalid on consecutive cycles, each with the correct data; never both asserted.
- cpu_req drops after 3 VGA wins, then reasserts -> defer_cnt clears to 0; CPU waits a full 4 more losses before the forced grant.
- rst asserted low one cycle after a VGA read grant -> vga_rvalid=0 immediately (async), defer_cnt=0; no rvalid after rst releases.
